// File: rtl/spn_pkg.sv
// Shared SPN primitives: opcodes, FSM states, 4-bit S-box, 16-bit bit shuffle and key schedule.
package spn_pkg;

    localparam int NUM_ROUNDS = 4;
    localparam int BLK_W      = 16;
    localparam int KEY_W      = 32;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ENC = 2'd1,
        OP_DEC = 2'd2,
        OP_ERR = 2'd3
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } spn_state_t;

    typedef logic [NUM_ROUNDS-1:0][BLK_W-1:0] round_key_t;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h1;  4'h1: y = 4'h2;  4'h2: y = 4'h9;  4'h3: y = 4'hC;
            4'h4: y = 4'h6;  4'h5: y = 4'hF;  4'h6: y = 4'h0;  4'h7: y = 4'hD;
            4'h8: y = 4'hA;  4'h9: y = 4'h4;  4'hA: y = 4'hB;  4'hB: y = 4'hE;
            4'hC: y = 4'h5;  4'hD: y = 4'h8;  4'hE: y = 4'h7;  default: y = 4'h3;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] isbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h6;  4'h1: y = 4'h0;  4'h2: y = 4'h1;  4'h3: y = 4'hF;
            4'h4: y = 4'h9;  4'h5: y = 4'hC;  4'h6: y = 4'h4;  4'h7: y = 4'hE;
            4'h8: y = 4'hD;  4'h9: y = 4'h2;  4'hA: y = 4'h8;  4'hB: y = 4'hA;
            4'hC: y = 4'h3;  4'hD: y = 4'h7;  4'hE: y = 4'hB;  default: y = 4'h5;
        endcase
        return y;
    endfunction

    function automatic logic [BLK_W-1:0] sbox16(input logic [BLK_W-1:0] x);
        logic [BLK_W-1:0] y;
        y = '0;
        for (int i = 0; i < 4; i++) y[4*i +: 4] = sbox4(x[4*i +: 4]);
        return y;
    endfunction

    function automatic logic [BLK_W-1:0] isbox16(input logic [BLK_W-1:0] x);
        logic [BLK_W-1:0] y;
        y = '0;
        for (int i = 0; i < 4; i++) y[4*i +: 4] = isbox4(x[4*i +: 4]);
        return y;
    endfunction

    // Bit b of nibble j moves to bit b of nibble (j+b)%4, spreading every nibble over all four.
    function automatic logic [BLK_W-1:0] pbox(input logic [BLK_W-1:0] x);
        logic [BLK_W-1:0] y;
        y = '0;
        for (int j = 0; j < 4; j++)
            for (int b = 0; b < 4; b++)
                y[4*((j+b)%4)+b] = x[4*j+b];
        return y;
    endfunction

    function automatic logic [BLK_W-1:0] ipbox(input logic [BLK_W-1:0] x);
        logic [BLK_W-1:0] y;
        y = '0;
        for (int j = 0; j < 4; j++)
            for (int b = 0; b < 4; b++)
                y[4*j+b] = x[4*((j+b)%4)+b];
        return y;
    endfunction

    function automatic round_key_t gen_round_keys(input logic [KEY_W-1:0] k);
        round_key_t rk;
        rk[0] = {k[7:0], k[23:16]};
        rk[1] = k[15:0];
        rk[2] = {k[7:0], k[31:24]};
        rk[3] = k[31:16];
        return rk;
    endfunction

endpackage

// File: rtl/spn_round_step.sv
// One SPN round step (combinational); dir_i=1 selects the decrypt schedule.
module spn_round_step
    import spn_pkg::*;
(
    input  logic [BLK_W-1:0] st_i,
    input  logic [BLK_W-1:0] d_i,
    input  round_key_t       rk_i,
    input  logic [1:0]       rnd_i,
    input  logic             dir_i,
    output logic [BLK_W-1:0] st_o
);

    always_comb begin
        st_o = st_i;
        if (!dir_i) begin
            case (rnd_i)
                2'd0:    st_o = pbox(sbox16(d_i ^ rk_i[0]));
                2'd1:    st_o = pbox(sbox16(st_i ^ rk_i[1]));
                2'd2:    st_o = sbox16(st_i ^ rk_i[2]);
                default: st_o = st_i ^ rk_i[3];
            endcase
        end else begin
            case (rnd_i)
                2'd0:    st_o = d_i ^ rk_i[3];
                2'd1:    st_o = isbox16(st_i) ^ rk_i[2];
                2'd2:    st_o = isbox16(ipbox(st_i)) ^ rk_i[1];
                default: st_o = isbox16(ipbox(st_i)) ^ rk_i[0];
            endcase
        end
    end

endmodule

// File: rtl/spn_iter_core.sv
// Iterative SPN engine: one round step per cycle behind valid/ready handshakes.
// Define SPN_STATS_EN to add saturating per-opcode completion counters.
module spn_iter_core
    import spn_pkg::*;
#(
    parameter int               CNT_W    = 16,
    parameter logic [BLK_W-1:0] ERR_DATA = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_opcode,
    input  logic [BLK_W-1:0] in_data,
    input  logic [KEY_W-1:0] in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             out_err,
    output logic             busy
`ifdef SPN_STATS_EN
    ,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] dec_count,
    output logic [CNT_W-1:0] err_count
`endif
);

    spn_state_t       state_q;
    opcode_t          op_q;
    opcode_t          op_in;
    logic [1:0]       rnd_q;
    logic [BLK_W-1:0] d_q;
    logic [KEY_W-1:0] key_q;
    logic [BLK_W-1:0] st_q, st_d;
    logic             out_valid_q, out_err_q, in_ready_q, busy_q;
    logic [BLK_W-1:0] out_data_q;
    round_key_t       rk;
    logic             dir;
    logic             out_hs;

    assign op_in  = opcode_t'(in_opcode);
    assign rk     = gen_round_keys(key_q);
    assign dir    = (op_q == OP_DEC);
    assign out_hs = (state_q == DONE) && out_ready;

    spn_round_step u_step (
        .st_i  (st_q),
        .d_i   (d_q),
        .rk_i  (rk),
        .rnd_i (rnd_q),
        .dir_i (dir),
        .st_o  (st_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_NOP;
            rnd_q       <= 2'd0;
            d_q         <= '0;
            key_q       <= '0;
            st_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        case (op_in)
                            OP_ENC, OP_DEC: begin
                                op_q       <= op_in;
                                d_q        <= in_data;
                                key_q      <= in_key;
                                rnd_q      <= 2'd0;
                                state_q    <= ROUND;
                                in_ready_q <= 1'b0;
                                busy_q     <= 1'b1;
                            end
                            OP_ERR: begin
                                op_q        <= OP_ERR;
                                state_q     <= DONE;
                                out_valid_q <= 1'b1;
                                out_data_q  <= ERR_DATA;
                                out_err_q   <= 1'b1;
                                in_ready_q  <= 1'b0;
                                busy_q      <= 1'b1;
                            end
                            default: ;  // NOP is consumed silently
                        endcase
                    end
                end
                ROUND: begin
                    st_q <= st_d;
                    // rnd saturates at 3: the last step leaves ROUND instead of wrapping
                    if (rnd_q == 2'd3) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= st_d;
                        out_err_q   <= 1'b0;
                    end else begin
                        rnd_q <= rnd_q + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign busy      = busy_q;

`ifdef SPN_STATS_EN
    logic [CNT_W-1:0] enc_cnt_q, dec_cnt_q, err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_cnt_q <= '0;
            dec_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (out_hs) begin
            if (op_q == OP_ENC && enc_cnt_q != '1) enc_cnt_q <= enc_cnt_q + 1'b1;
            if (op_q == OP_DEC && dec_cnt_q != '1) dec_cnt_q <= dec_cnt_q + 1'b1;
            if (op_q == OP_ERR && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign enc_count = enc_cnt_q;
    assign dec_count = dec_cnt_q;
    assign err_count = err_cnt_q;
`else
    logic unused_hs;
    assign unused_hs = out_hs;
`endif

endmodule
